// File: rtl/sync_down_counter_tff.sv
// Loadable synchronous down counter built from toggle cells, with a terminal-count
// look-ahead, a registered done pulse and an optional auto-reload from the last loaded value.
module sync_down_counter_tff #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] toggle;
  logic             q_is_zero;

  // Bit i flips when every lower bit is zero: the borrow chain of a decrement.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
    if (gi == 0) begin : g_lsb
      assign toggle[gi] = 1'b1;
    end else begin : g_bit
      assign toggle[gi] = ~|q_q[gi-1:0];
    end
  end

  assign q_is_zero = (q_q == '0);

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (load_i) begin
      q_d   = d_i;
      rld_d = d_i;
      if (start_i) begin
        state_d = RUN;
      end else if (state_q == HALT) begin
        state_d = IDLE;
      end
    end else if (start_i && (state_q != RUN)) begin
      state_d = RUN;
      if (state_q == HALT) begin
        q_d = rld_q;
      end
    end else if ((state_q == RUN) && en_i) begin
      if (q_is_zero) begin
        // Terminal edge: never wrap to all-ones.
        done_d = 1'b1;
        if (AUTO_RELOAD) begin
          q_d = rld_q;
        end else begin
          state_d = HALT;
        end
      end else begin
        q_d = q_q ^ toggle;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
    end
  end

  assign q_o    = q_q;
  assign busy_o = (state_q == RUN);
  assign tc_o   = busy_o & en_i & q_is_zero;
  assign done_o = done_q;

endmodule
